// File: rtl/keypad_debounce_scheduler.sv
// Debounces N_KEYS raw panel buttons through one shared qualification timer,
// scanning round-robin and handing qualified presses to the control FSM via valid/ready.
module keypad_debounce_scheduler #(
  parameter int N_KEYS        = 4,
  parameter int IDX_W         = 2,
  parameter int STABLE_CYCLES = 8
) (
  input  logic              i_clk,
  input  logic              i_clear,
  input  logic [N_KEYS-1:0] i_key_raw,
  input  logic              i_key_ready,
  output logic              o_key_valid,
  output logic [IDX_W-1:0]  o_key_code,
  output logic [N_KEYS-1:0] o_key_held,
  output logic              o_busy
);

  localparam int CNT_W = (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [IDX_W-1:0] IDX_MAX = IDX_W'(N_KEYS - 1);

  typedef enum logic [1:0] {SCAN, QUALIFY, REPORT} state_t;

  state_t            r_state, w_state_nxt;
  logic [N_KEYS-1:0] r_s1, r_s2;
  logic [N_KEYS-1:0] r_held, w_held_nxt;
  logic              r_valid, w_valid_nxt;
  logic [IDX_W-1:0]  r_code, w_code_nxt;
  logic [IDX_W-1:0]  r_ptr, w_ptr_nxt;
  logic [IDX_W-1:0]  r_cand, w_cand_nxt;
  logic [CNT_W-1:0]  r_cnt, w_cnt_nxt;

  logic [N_KEYS-1:0] w_diff;
  logic              w_found;
  logic [IDX_W-1:0]  w_hit;
  logic [IDX_W-1:0]  w_cand_inc;

  assign w_diff     = r_s2 ^ r_held;
  assign w_cand_inc = (r_cand == IDX_MAX) ? '0 : r_cand + 1'b1;

  // First key differing from its debounced level, searching upward from r_ptr with wrap.
  always_comb begin
    int               j;
    logic [IDX_W-1:0] idx;
    j       = 0;
    idx     = '0;
    w_found = 1'b0;
    w_hit   = '0;
    for (int k = 0; k < N_KEYS; k++) begin
      j   = (int'(r_ptr) + k) % N_KEYS;
      idx = IDX_W'(j);
      if (!w_found && w_diff[idx]) begin
        w_found = 1'b1;
        w_hit   = idx;
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_held_nxt  = r_held;
    w_valid_nxt = r_valid;
    w_code_nxt  = r_code;
    w_ptr_nxt   = r_ptr;
    w_cand_nxt  = r_cand;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      SCAN: begin
        if (w_found) begin
          w_cand_nxt  = w_hit;
          w_cnt_nxt   = '0;
          w_state_nxt = QUALIFY;
        end
      end
      QUALIFY: begin
        if (!w_diff[r_cand]) begin
          w_state_nxt = SCAN;
          w_ptr_nxt   = w_cand_inc;
        end else if (r_cnt != CNT_MAX) begin
          w_cnt_nxt = r_cnt + 1'b1;
        end else begin
          w_held_nxt[r_cand] = r_s2[r_cand];
          // Only presses are reported; a release just updates the held level.
          if (r_s2[r_cand]) begin
            w_valid_nxt = 1'b1;
            w_code_nxt  = r_cand;
            w_state_nxt = REPORT;
          end else begin
            w_state_nxt = SCAN;
            w_ptr_nxt   = w_cand_inc;
          end
        end
      end
      REPORT: begin
        if (r_valid && i_key_ready) begin
          w_valid_nxt = 1'b0;
          w_state_nxt = SCAN;
          w_ptr_nxt   = w_cand_inc;
        end
      end
      default: w_state_nxt = SCAN;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_clear) begin
      r_s1    <= '0;
      r_s2    <= '0;
      r_held  <= '0;
      r_valid <= 1'b0;
      r_code  <= '0;
      r_ptr   <= '0;
      r_cand  <= '0;
      r_cnt   <= '0;
      r_state <= SCAN;
    end else begin
      r_s1    <= i_key_raw;
      r_s2    <= r_s1;
      r_held  <= w_held_nxt;
      r_valid <= w_valid_nxt;
      r_code  <= w_code_nxt;
      r_ptr   <= w_ptr_nxt;
      r_cand  <= w_cand_nxt;
      r_cnt   <= w_cnt_nxt;
      r_state <= w_state_nxt;
    end
  end

  assign o_key_valid = r_valid;
  assign o_key_code  = r_code;
  assign o_key_held  = r_held;
  assign o_busy      = (r_state != SCAN);

endmodule

// File: tb/tb_keypad_debounce_scheduler.sv
// Directed scenarios plus random key activity, checked every cycle against a
// timestamp-based model of the shared debounce scheduler.
module tb_keypad_debounce_scheduler;
  localparam int N  = 4;
  localparam int IW = 2;
  localparam int SC = 8;

  logic          clk;
  logic          clear;
  logic [N-1:0]  raw;
  logic          ready;
  logic          valid;
  logic [IW-1:0] code;
  logic [N-1:0]  held;
  logic          busy;

  int n_chk  = 0;
  int n_fail = 0;

  keypad_debounce_scheduler #(.N_KEYS(N), .IDX_W(IW), .STABLE_CYCLES(SC)) dut (
    .i_clk(clk), .i_clear(clear), .i_key_raw(raw), .i_key_ready(ready),
    .o_key_valid(valid), .o_key_code(code), .o_key_held(held), .o_busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: pipeline of sampled levels, debounced levels, and one
  // qualification window identified by the edge number it opened on.
  bit [N-1:0] m_s1 = '0, m_s2 = '0, m_held = '0;
  bit         m_valid = 1'b0;
  int         m_code = 0, m_ptr = 0, m_cand = 0, m_t0 = 0;
  int         m_mode = 0;  // 0 idle, 1 qualifying, 2 reporting
  int         edge_no = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (edge %0d)", tag, obs, exp, edge_no);
    end
  endtask

  task automatic model_edge();
    edge_no++;
    if (clear) begin
      m_s1 = '0; m_s2 = '0; m_held = '0; m_valid = 1'b0;
      m_code = 0; m_ptr = 0; m_cand = 0; m_mode = 0;
      return;
    end
    if (m_mode == 0) begin
      for (int k = 0; k < N; k++) begin
        int i;
        i = (m_ptr + k) % N;
        if (m_s2[i] != m_held[i]) begin
          m_cand = i; m_t0 = edge_no; m_mode = 1;
          break;
        end
      end
    end else if (m_mode == 1) begin
      if (m_s2[m_cand] == m_held[m_cand]) begin
        m_mode = 0; m_ptr = (m_cand + 1) % N;
      end else if (edge_no - m_t0 == SC) begin
        m_held[m_cand] = m_s2[m_cand];
        if (m_held[m_cand]) begin
          m_valid = 1'b1; m_code = m_cand; m_mode = 2;
        end else begin
          m_mode = 0; m_ptr = (m_cand + 1) % N;
        end
      end
    end else if (ready) begin
      m_valid = 1'b0; m_mode = 0; m_ptr = (m_cand + 1) % N;
    end
    m_s2 = m_s1;
    m_s1 = raw;
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    chk("valid", 32'(valid), 32'(m_valid));
    chk("held", 32'(held), 32'(m_held));
    chk("busy", 32'(busy), 32'(m_mode != 0));
    if (m_valid) chk("code", 32'(code), 32'(m_code));
  endtask

  task automatic do_clear();
    clear = 1'b1;
    step();
    clear = 1'b0;
  endtask

  initial begin
    int n;
    int pulses;
    int codes[$];
    clear = 1'b1; raw = '0; ready = 1'b0;

    // Reset state
    step(); step();
    chk("rst_valid", 32'(valid), 0);
    chk("rst_code", 32'(code), 0);
    chk("rst_held", 32'(held), 0);
    chk("rst_busy", 32'(busy), 0);
    clear = 1'b0;
    step(); step();

    // Clean press of key 1: valid after edge STABLE_CYCLES+3, one cycle
    raw = 4'b0010; ready = 1'b1;
    for (int e = 1; e <= 12; e++) begin
      step();
      if (e == SC + 2) chk("t1_early", 32'(valid), 0);
      if (e == SC + 3) begin
        chk("t1_valid", 32'(valid), 1);
        chk("t1_code", 32'(code), 1);
        chk("t1_held", 32'(held), 32'h2);
      end
      if (e == SC + 4) chk("t1_drop", 32'(valid), 0);
    end

    // Key 2 bounces every 3 cycles then settles
    pulses = 0;
    for (int c = 0; c < 30; c++) begin
      raw[2] = ((c / 3) % 2 == 0);
      step();
      if (valid) pulses++;
    end
    chk("t2_bounce", 32'(pulses), 0);
    raw[2] = 1'b1;
    for (int c = 0; c < 40; c++) begin
      step();
      if (valid) begin
        pulses++;
        chk("t2_code", 32'(code), 2);
      end
    end
    chk("t2_pulses", 32'(pulses), 1);

    // Release key 1: held drops after STABLE_CYCLES+3 edges, no pulse
    raw[1] = 1'b0;
    for (int e = 1; e <= SC + 3; e++) begin
      step();
      chk("t4_novalid", 32'(valid), 0);
      if (e == SC + 2) chk("t4_still", 32'(held[1]), 1);
      if (e == SC + 3) chk("t4_rel", 32'(held[1]), 0);
    end
    raw = '0;
    repeat (15) step();

    // Keys 0 and 3 together with the consumer stalled
    do_clear();
    raw = 4'b1001; ready = 1'b0;
    n = 0;
    while (!valid && n < 40) begin step(); n++; end
    chk("t3_timeout", 32'(valid), 1);
    for (int c = 0; c < 5; c++) begin
      step();
      chk("t3_hold_v", 32'(valid), 1);
      chk("t3_hold_c", 32'(code), 0);
    end
    ready = 1'b1;
    step();
    chk("t3_ack", 32'(valid), 0);
    n = 0;
    while (!valid && n < 40) begin step(); n++; end
    chk("t3_gap", 32'(n), SC + 1);
    chk("t3_code", 32'(code), 3);
    step();
    raw = '0;
    repeat (20) step();

    // Clear mid-qualification of key 2
    do_clear();
    raw = 4'b0100;
    repeat (6) step();
    chk("t5_busy", 32'(busy), 1);
    clear = 1'b1;
    step();
    chk("t5_valid", 32'(valid), 0);
    chk("t5_held", 32'(held), 0);
    chk("t5_busy0", 32'(busy), 0);
    chk("t5_code", 32'(code), 0);
    clear = 1'b0;
    n = 0;
    while (!valid && n < 40) begin step(); n++; end
    chk("t5_gap", 32'(n), SC + 3);
    chk("t5_rcode", 32'(code), 2);
    raw = '0;
    repeat (20) step();

    // All four keys at once, immediate handshakes
    do_clear();
    raw = 4'b1111;
    n = 0;
    while (codes.size() < 4 && n < 100) begin
      step(); n++;
      if (valid) codes.push_back(int'(code));
    end
    chk("t6_count", 32'(codes.size()), 4);
    for (int i = 0; i < codes.size(); i++) chk("t6_order", 32'(codes[i]), 32'(i));
    raw = '0;
    repeat (60) step();

    // Random key activity with varying bounce rate, stalls and clears
    begin
      int rate;
      rate = 8;
      for (int c = 0; c < 4000; c++) begin
        if (c % 500 == 0) rate = $urandom_range(3, 40);
        for (int k = 0; k < N; k++)
          if ($urandom_range(0, rate - 1) == 0) raw[k] = ~raw[k];
        ready = 1'($urandom_range(0, 1));
        clear = ($urandom_range(0, 299) == 0);
        step();
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
